// File: rtl/vec_pkg.sv
// Shared types for the VRF operation sequencer: opcodes, FSM states, element type
// and a clog2 helper that never returns zero.
package vec_pkg;

  localparam int unsigned vec_vdw_gp = 32;

  typedef logic [vec_vdw_gp-1:0] elem_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4
  } vec_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } vrf_seq_state_e;

  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// One-element combinational ALU used once per lane by the VRF sequencer.
// Define VRF_OP_SEQ_SATURATE_EN to clamp ADD/SUB instead of wrapping.
module vec_lane_alu
  import vec_pkg::*;
#(
  parameter int unsigned width_p = vec_vdw_gp
) (
  input  logic [2:0]         op_i,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  output logic [width_p-1:0] res_o,
  output logic               illegal_o
);

`ifdef VRF_OP_SEQ_SATURATE_EN
  // Extra MSB carries the carry-out of ADD and the borrow of SUB.
  logic [width_p:0] w_sum;
  logic [width_p:0] w_diff;

  assign w_sum  = {1'b0, a_i} + {1'b0, b_i};
  assign w_diff = {1'b0, a_i} - {1'b0, b_i};
`else
  logic [width_p-1:0] w_sum;
  logic [width_p-1:0] w_diff;

  assign w_sum  = a_i + b_i;
  assign w_diff = a_i - b_i;
`endif

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch is inferred.
    res_o     = '0;
    illegal_o = 1'b0;
    case (op_i)
`ifdef VRF_OP_SEQ_SATURATE_EN
      OP_ADD:  res_o = w_sum[width_p]  ? '1 : w_sum[width_p-1:0];
      OP_SUB:  res_o = w_diff[width_p] ? '0 : w_diff[width_p-1:0];
`else
      OP_ADD:  res_o = w_sum;
      OP_SUB:  res_o = w_diff;
`endif
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/vrf_op_sequencer.sv
// VRF initiator: reads vs1/vs2, runs an element-wise op lanes_p elements per beat,
// writes the result to vd. VRF_OP_SEQ_SATURATE_EN selects clamping ADD/SUB.
module vrf_op_sequencer
  import vec_pkg::*;
#(
  parameter  int unsigned els_p            = 32,
  parameter  int unsigned vlen_p           = 8,
  parameter  int unsigned vdw_p            = 32,
  parameter  int unsigned lanes_p          = 4,
  localparam int unsigned addr_width_lp    = safe_clog2(els_p),
  localparam int unsigned rw_data_width_lp = vlen_p * vdw_p
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic                                  v_i,
  output logic                                  ready_o,
  input  logic [2:0]                            op_i,
  input  logic [addr_width_lp-1:0]              vd_i,
  input  logic [addr_width_lp-1:0]              vs1_i,
  input  logic [addr_width_lp-1:0]              vs2_i,
  output logic [lanes_p*addr_width_lp-1:0]      r_addr_o,
  input  logic [lanes_p*rw_data_width_lp-1:0]   r_data_i,
  output logic [lanes_p*addr_width_lp-1:0]      w_addr_o,
  output logic [lanes_p*rw_data_width_lp-1:0]   w_data_o,
  output logic [lanes_p-1:0]                    w_en_o,
  output logic                                  done_o,
  output logic                                  err_o
);

  localparam int unsigned beats_lp     = vlen_p / lanes_p;
  localparam int unsigned beat_w_lp    = safe_clog2(beats_lp);
  localparam int unsigned beat_bits_lp = lanes_p * vdw_p;
  localparam int unsigned aw_lp        = addr_width_lp;
  localparam int unsigned rw_lp        = rw_data_width_lp;

  vrf_seq_state_e             r_state;
  vrf_seq_state_e             w_state_next;
  logic [2:0]                 r_op;
  logic [aw_lp-1:0]           r_vd;
  logic [aw_lp-1:0]           r_vs1;
  logic [aw_lp-1:0]           r_vs2;
  logic [rw_lp-1:0]           r_opa;
  logic [rw_lp-1:0]           r_opb;
  logic [rw_lp-1:0]           r_result;
  logic [beat_w_lp-1:0]       r_beat;

  logic                       w_accept;
  logic                       w_last_beat;
  logic                       w_illegal;
  logic [beat_bits_lp-1:0]    w_lane_a;
  logic [beat_bits_lp-1:0]    w_lane_b;
  logic [beat_bits_lp-1:0]    w_lane_res;
  logic [lanes_p-1:0]         w_lane_illegal;
  logic                       w_unused_rdata;

  assign w_accept       = v_i & ready_o;
  assign w_last_beat    = (r_beat == beat_w_lp'(beats_lp - 1));
  assign w_lane_a       = r_opa[int'(r_beat) * beat_bits_lp +: beat_bits_lp];
  assign w_lane_b       = r_opb[int'(r_beat) * beat_bits_lp +: beat_bits_lp];
  assign w_illegal      = |w_lane_illegal;
  // Only ports 0 and 1 carry operands; the remaining read data is ignored.
  assign w_unused_rdata = ^r_data_i[lanes_p*rw_lp-1:2*rw_lp];

  for (genvar l = 0; l < lanes_p; l++) begin : g_lane
    vec_lane_alu #(.width_p(vdw_p)) u_alu (
      .op_i      (r_op),
      .a_i       (w_lane_a[l*vdw_p +: vdw_p]),
      .b_i       (w_lane_b[l*vdw_p +: vdw_p]),
      .res_o     (w_lane_res[l*vdw_p +: vdw_p]),
      .illegal_o (w_lane_illegal[l])
    );
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!reset_n_i) r_state <= IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = READ;
      READ:    w_state_next = EXEC;
      EXEC:    if (w_last_beat) w_state_next = WB;
      WB:      w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      // NOTE: operand/result vectors are cleared as well, so an aborted op leaves nothing stale.
      r_op     <= '0;
      r_vd     <= '0;
      r_vs1    <= '0;
      r_vs2    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_beat   <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= op_i;
        r_vd  <= vd_i;
        r_vs1 <= vs1_i;
        r_vs2 <= vs2_i;
      end
      if (r_state == READ) begin
        r_opa <= r_data_i[0 +: rw_lp];
        r_opb <= r_data_i[rw_lp +: rw_lp];
      end
      if (r_state == EXEC) begin
        r_result[int'(r_beat) * beat_bits_lp +: beat_bits_lp] <= w_lane_res;
        r_beat <= w_last_beat ? '0 : r_beat + beat_w_lp'(1);
      end
    end
  end

  always_comb begin
    ready_o  = (r_state == IDLE);
    r_addr_o = '0;
    w_addr_o = '0;
    w_data_o = '0;
    w_en_o   = '0;
    done_o   = 1'b0;
    err_o    = 1'b0;
    if (r_state != IDLE) begin
      r_addr_o[0 +: aw_lp]     = r_vs1;
      r_addr_o[aw_lp +: aw_lp] = r_vs2;
    end
    if (r_state == WB) begin
      w_en_o[0]            = 1'b1;
      w_addr_o[0 +: aw_lp] = r_vd;
      w_data_o[0 +: rw_lp] = r_result;
      done_o               = 1'b1;
      err_o                = w_illegal;
    end
  end

endmodule

// File: tb/tb_vrf_op_sequencer.sv
// Directed self-checking bench for vrf_op_sequencer with a behavioural VRF.
// Saturating expectations are selected by VRF_OP_SEQ_SATURATE_EN.
module tb_vrf_op_sequencer;
  import vec_pkg::*;

  localparam int AW = 5;
  localparam int RW = 256;
  localparam int L  = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            v = 1'b0;
  logic            ready;
  logic [2:0]      op = '0;
  logic [AW-1:0]   vd = '0;
  logic [AW-1:0]   vs1 = '0;
  logic [AW-1:0]   vs2 = '0;
  logic [L*AW-1:0] r_addr;
  logic [L*RW-1:0] r_data;
  logic [L*AW-1:0] w_addr;
  logic [L*RW-1:0] w_data;
  logic [L-1:0]    w_en;
  logic            done;
  logic            err;

  logic [RW-1:0]   vrf [32];
  int              cyc = 0;
  int              wb_count = 0;
  int              n_wb_exp = 0;
  int              n_checks = 0;
  int              n_errors = 0;

  vrf_op_sequencer #(.els_p(32), .vlen_p(8), .vdw_p(32), .lanes_p(4)) u_dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .v_i       (v),
    .ready_o   (ready),
    .op_i      (op),
    .vd_i      (vd),
    .vs1_i     (vs1),
    .vs2_i     (vs2),
    .r_addr_o  (r_addr),
    .r_data_i  (r_data),
    .w_addr_o  (w_addr),
    .w_data_o  (w_data),
    .w_en_o    (w_en),
    .done_o    (done),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  always_comb begin
    r_data = '0;
    for (int l = 0; l < L; l++) r_data[l*RW +: RW] = vrf[r_addr[l*AW +: AW]];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (w_en[0]) wb_count <= wb_count + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] pack8(input elem_t e0, e1, e2, e3, e4, e5, e6, e7);
    return {e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, " ready"},  RW'(ready), RW'(1'b1));
    check({tag, " r_addr"}, RW'(r_addr), '0);
    check({tag, " w_addr"}, RW'(w_addr), '0);
    check({tag, " w_data"}, RW'(w_data == '0), RW'(1'b1));
    check({tag, " w_en"},   RW'(w_en), '0);
    check({tag, " done"},   RW'(done), '0);
    check({tag, " err"},    RW'(err), '0);
  endtask

  // Waits (bounded) for the writeback pulse and checks it against the expected write.
  task automatic wait_wb(input string tag, input logic [AW-1:0] t_vd, input logic [RW-1:0] exp,
                         input logic exp_err, input int c0, input int lat);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 16 && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        check({tag, " latency"}, RW'(cyc - c0), RW'(lat));
        check({tag, " w_en"},    RW'(w_en), RW'(4'b0001));
        check({tag, " w_addr"},  RW'(w_addr), RW'({15'b0, t_vd}));
        check({tag, " w_data"},  w_data[RW-1:0], exp);
        check({tag, " w_hi"},    RW'(w_data[L*RW-1:RW] == '0), RW'(1'b1));
        check({tag, " err"},     RW'(err), RW'(exp_err));
      end
    end
    check({tag, " done seen"}, RW'(seen), RW'(1'b1));
  endtask

  task automatic run_op(input string tag, input logic [2:0] t_op, input logic [AW-1:0] t_vd,
                        input logic [AW-1:0] t_vs1, input logic [AW-1:0] t_vs2,
                        input logic [RW-1:0] exp, input logic exp_err, input logic noise);
    int c0;
    @(negedge clk);
    check({tag, " ready"}, RW'(ready), RW'(1'b1));
    v = 1'b1; op = t_op; vd = t_vd; vs1 = t_vs1; vs2 = t_vs2;
    c0 = cyc;
    @(posedge clk); #1;
    v = noise; op = OP_ADD; vd = 5'd20; vs1 = 5'd8; vs2 = 5'd9;
    @(negedge clk);
    check({tag, " r_addr"}, RW'(r_addr), RW'({10'b0, t_vs2, t_vs1}));
    wait_wb(tag, t_vd, exp, exp_err, c0, 4);
    v = 1'b0;
    vrf[t_vd] = exp;
    n_wb_exp++;
    @(posedge clk); #1;
    check({tag, " wb count"}, RW'(wb_count), RW'(n_wb_exp));
  endtask

  logic [RW-1:0] exp_add_wrap, exp_sub_wrap, v1, v2;
  int c0;
  int base;

  initial begin
    for (int r = 0; r < 32; r++) vrf[r] = {8{32'hDEAD_0000 + 32'(r)}};
    v1 = pack8(0, 1, 2, 3, 4, 5, 6, 7);
    v2 = pack8(0, 10, 20, 30, 40, 50, 60, 70);
    vrf[1]  = v1;
    vrf[2]  = v2;
    vrf[8]  = {8{32'hFFFF_FFFF}};
    vrf[9]  = {8{32'h0000_0001}};
    vrf[11] = '0;
    vrf[13] = {8{32'h0000_000F}};
`ifdef VRF_OP_SEQ_SATURATE_EN
    exp_add_wrap = {8{32'hFFFF_FFFF}};
    exp_sub_wrap = '0;
`else
    exp_add_wrap = '0;
    exp_sub_wrap = {8{32'hFFFF_FFFF}};
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("in reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after reset");

    run_op("add v3", OP_ADD, 5'd3, 5'd1, 5'd2, pack8(0, 11, 22, 33, 44, 55, 66, 77), 1'b0, 1'b0);
    run_op("add ovf", OP_ADD, 5'd4, 5'd8, 5'd9, exp_add_wrap, 1'b0, 1'b0);
    run_op("sub unf", OP_SUB, 5'd10, 5'd11, 5'd9, exp_sub_wrap, 1'b0, 1'b0);
    run_op("sub v15", OP_SUB, 5'd15, 5'd2, 5'd1, pack8(0, 9, 18, 27, 36, 45, 54, 63), 1'b0, 1'b0);
    run_op("and v12", OP_AND, 5'd12, 5'd2, 5'd13, pack8(0, 10, 4, 14, 8, 2, 12, 6), 1'b0, 1'b1);
    run_op("or v14", OP_OR, 5'd14, 5'd1, 5'd2, pack8(0, 11, 22, 31, 44, 55, 62, 71), 1'b0, 1'b1);
    run_op("illegal 6", 3'd6, 5'd5, 5'd1, 5'd2, '0, 1'b1, 1'b0);
    run_op("xor v6", OP_XOR, 5'd6, 5'd1, 5'd2, pack8(0, 11, 22, 29, 44, 55, 58, 65), 1'b0, 1'b0);
    run_op("illegal 5", 3'd5, 5'd17, 5'd1, 5'd2, '0, 1'b1, 1'b1);
    run_op("illegal 7", 3'd7, 5'd18, 5'd8, 5'd9, '0, 1'b1, 1'b0);
    run_op("xor self", OP_XOR, 5'd7, 5'd7, 5'd7, '0, 1'b0, 1'b0);
    run_op("add vd=vs1", OP_ADD, 5'd1, 5'd1, 5'd2, pack8(0, 11, 22, 33, 44, 55, 66, 77), 1'b0, 1'b0);
    v1 = vrf[1];

    // Back-to-back with v_i held high: second accept lands five cycles after the first.
    @(negedge clk);
    v = 1'b1; op = OP_XOR; vd = 5'd22; vs1 = 5'd2; vs2 = 5'd13;
    c0 = cyc;
    @(posedge clk); #1;
    op = OP_SUB; vd = 5'd23; vs1 = 5'd1; vs2 = 5'd2;
    wait_wb("b2b first", 5'd22, pack8(15, 5, 27, 17, 39, 61, 51, 73), 1'b0, c0, 4);
    vrf[22] = pack8(15, 5, 27, 17, 39, 61, 51, 73);
    n_wb_exp++;
    @(negedge clk);
    check("b2b ready", RW'(ready), RW'(1'b1));
    check("b2b accept gap", RW'(cyc - c0), RW'(5));
    @(posedge clk); #1;
    v = 1'b0;
    wait_wb("b2b second", 5'd23, pack8(0, 1, 2, 3, 4, 5, 6, 7), 1'b0, c0, 9);
    vrf[23] = pack8(0, 1, 2, 3, 4, 5, 6, 7);
    n_wb_exp++;
    @(posedge clk); #1;
    check("b2b wb count", RW'(wb_count), RW'(n_wb_exp));

    // Reset asserted during EXEC beat 1 must abort without any write.
    @(negedge clk);
    v = 1'b1; op = OP_ADD; vd = 5'd21; vs1 = 5'd1; vs2 = 5'd2;
    c0 = cyc;
    @(posedge clk); #1;
    v = 1'b0;
    base = wb_count;
    repeat (3) @(negedge clk);
    check("abort in exec", RW'(cyc - c0), RW'(3));
    reset_n = 1'b0;
    @(negedge clk);
    check("abort w_en", RW'(w_en), '0);
    check("abort done", RW'(done), '0);
    reset_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post abort");
    repeat (6) @(negedge clk);
    check("abort no write", RW'(wb_count), RW'(base));

    run_op("after abort", OP_OR, 5'd21, 5'd9, 5'd11, {8{32'h0000_0001}}, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
